// File: rtl/phy_tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// phy_tx_sched_pkg
// Shared definitions for the PHY transmit scheduler: FSM state encoding and
// the fixed 32-bit words driven onto the TX datapath.
//   state_e        : IDLE=0, TRAIN=1, ACTIVE=2, SKIP=3 (SKIP reserved when
//                    PHY_TX_SCHED_SKP_EN is undefined)
//   TRAIN_PATTERN  : word repeated during link training
//   SKP_PATTERN    : SKP ordered-set word
//   IDLE_WORD      : value of tx_data whenever tx_valid is low
// ---------------------------------------------------------------------------
package phy_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_SKIP   = 2'd3
  } state_e;

  localparam logic [31:0] TRAIN_PATTERN = 32'hBCBC_4A4A;
  localparam logic [31:0] SKP_PATTERN   = 32'hBC1C_1C1C;
  localparam logic [31:0] IDLE_WORD     = 32'h0000_0000;

endpackage

// File: rtl/phy_tx_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. The grant is combinational from the
// requests and the pointer; the pointer is registered and only moves while
// en is high.
//   clk_f  : clock
//   reset  : asynchronous, active-high reset (pointer -> requester 0)
//   en     : arbitration enable; grant is forced to 0 while low
//   req    : request vector, bit i = requester i has a word
//   grant  : one-hot grant (or zero)
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk_f,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // ptr names the requester that wins when both request.
  logic ptr;

  // NOTE: every always_comb output gets a default first so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // After any grant the pointer names the requester that was not served;
  // with no grant it holds.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (en && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/phy_tx_sched.sv
// ---------------------------------------------------------------------------
// phy_tx_sched
// Link-side transmit scheduler in front of the PHY TX datapath. After reset
// it sends TRAIN_WORDS training words, then arbitrates round-robin between
// two 32-bit requesters, emitting one registered word per clk_f cycle, and
// periodically inserts a SKP ordered-set word.
//
// Build option: PHY_TX_SCHED_SKP_EN
//   defined   : a SKP word is inserted after every SKP_INTERVAL ACTIVE cycles
//   undefined : no SKP counter; ACTIVE is left only by retrain or reset
//
// Ports:
//   clk_f                  : word-rate clock
//   reset                  : asynchronous, active-high reset
//   retrain                : return to training (honoured in ACTIVE only)
//   req0_data/valid/ready  : requester 0 word handshake
//   req1_data/valid/ready  : requester 1 word handshake
//   tx_data, tx_valid      : registered word to the TX datapath
//   link_up                : high in ACTIVE and SKIP
//   state                  : current FSM state (debug)
// ---------------------------------------------------------------------------
module phy_tx_sched
  import phy_tx_sched_pkg::*;
#(
  parameter int TRAIN_WORDS  = 8,
  parameter int SKP_INTERVAL = 16
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        retrain,
  input  logic [31:0] req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        link_up,
  output logic [1:0]  state
);

  state_e      state_q, state_d;
  logic [7:0]  train_cnt;
  logic        train_last;
  logic        skp_hit;
  logic        arb_en;
  logic [1:0]  grant;
  logic [31:0] tx_data_d;
  logic        tx_valid_d;

  assign train_last = (train_cnt == 8'(TRAIN_WORDS - 1));
  assign arb_en     = (state_q == ST_ACTIVE);

  rr_arb2 u_arb (
    .clk_f (clk_f),
    .reset (reset),
    .en    (arb_en),
    .req   ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign link_up    = (state_q == ST_ACTIVE) || (state_q == ST_SKIP);
  assign state      = state_q;

`ifdef PHY_TX_SCHED_SKP_EN
  logic [9:0] skp_cnt;

  assign skp_hit = (skp_cnt == 10'(SKP_INTERVAL - 1));

  // Counts every ACTIVE cycle, granted or not; holds in SKIP so the interval
  // is measured in ACTIVE cycles only. Entering TRAIN via retrain clears it.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      skp_cnt <= '0;
    end else if (state_q == ST_ACTIVE) begin
      if (retrain || skp_hit) skp_cnt <= '0;
      else                    skp_cnt <= skp_cnt + 10'd1;
    end
  end
`else
  assign skp_hit = 1'b0;
`endif

  // Next state and the word to register on the coming edge.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = IDLE_WORD;
    tx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        tx_data_d  = TRAIN_PATTERN;
        tx_valid_d = 1'b1;
        if (train_last) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (grant[0]) begin
          tx_data_d  = req0_data;
          tx_valid_d = 1'b1;
        end else if (grant[1]) begin
          tx_data_d  = req1_data;
          tx_valid_d = 1'b1;
        end
        // The grant above completes either way; retrain outranks a due SKP.
        if (retrain)      state_d = ST_TRAIN;
        else if (skp_hit) state_d = ST_SKIP;
      end
      ST_SKIP: begin
        tx_data_d  = SKP_PATTERN;
        tx_valid_d = 1'b1;
        state_d    = ST_ACTIVE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      train_cnt <= '0;
      tx_data   <= IDLE_WORD;
      tx_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      // Counter runs only inside TRAIN, so any entry into TRAIN starts at 0.
      if (state_q == ST_TRAIN && !train_last) train_cnt <= train_cnt + 8'd1;
      else                                    train_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_phy_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_phy_tx_sched
// Table-driven bench for phy_tx_sched with default parameters
// (TRAIN_WORDS=8, SKP_INTERVAL=16). Each table row covers one clock period:
// inputs are driven on the falling edge and every output is checked 1 ns
// later, so readies reflect this period's inputs and tx_data/tx_valid/state
// reflect the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_phy_tx_sched;

  localparam logic [31:0] TP = 32'hBCBC_4A4A;
  localparam logic [31:0] SP = 32'hBC1C_1C1C;
  localparam logic [1:0]  S_IDLE = 2'd0, S_TRAIN = 2'd1,
                          S_ACT  = 2'd2, S_SKIP  = 2'd3;

  logic        clk_f = 1'b0;
  logic        reset;
  logic        retrain;
  logic [31:0] req0_data, req1_data;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        link_up;
  logic [1:0]  state;

  always #5 clk_f = ~clk_f;

  phy_tx_sched dut (
    .clk_f      (clk_f),
    .reset      (reset),
    .retrain    (retrain),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .link_up    (link_up),
    .state      (state)
  );

  typedef struct {
    logic        rt;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic [31:0] txd;
    logic        txv;
    logic        lu;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic rt, input logic v0, input logic [31:0] d0,
                     input logic v1, input logic [31:0] d1,
                     input logic r0, input logic r1,
                     input logic [31:0] txd, input logic txv,
                     input logic lu, input logic [1:0] st);
    vec_t v;
    v.rt = rt; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.txd = txd; v.txv = txv; v.lu = lu; v.st = st;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] wa(input int n);
    return 32'hA000_0000 + 32'(n);
  endfunction

  function automatic logic [31:0] wb(input int n);
    return 32'hB000_0000 + 32'(n);
  endfunction

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " req0_ready"}, 32'(req0_ready), 32'(v.r0));
    check({tag, " req1_ready"}, 32'(req1_ready), 32'(v.r1));
    check({tag, " tx_data"},    tx_data,         v.txd);
    check({tag, " tx_valid"},   32'(tx_valid),   32'(v.txv));
    check({tag, " link_up"},    32'(link_up),    32'(v.lu));
    check({tag, " state"},      32'(state),      32'(v.st));
  endtask

  // Called on a falling edge; returns on the falling edge after row hi.
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      retrain    = tbl[i].rt;
      req0_valid = tbl[i].v0;
      req0_data  = tbl[i].d0;
      req1_valid = tbl[i].v1;
      req1_data  = tbl[i].d1;
      #1;
      check_outputs($sformatf("row%0d", i), tbl[i]);
      @(negedge clk_f);
    end
  endtask

  initial begin
    vec_t rst_v;
    reset      = 1'b1;
    retrain    = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // ---- table: rows 0-9 training, 10-22 arbitration ----
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_IDLE);        // 0: single IDLE cycle
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_TRAIN);       // 1
    for (int k = 2; k <= 8; k++)
      add(0, 0, 0, 0, 0, 0, 0, TP, 1, 0, S_TRAIN);    // 2..8: words 1..7
    add(0, 0, 0, 0, 0, 0, 0, TP, 1, 1, S_ACT);        // 9: word 8, link up
    add(0, 1, wa(0), 1, wb(0), 1, 0, 0,     0, 1, S_ACT);  // 10
    add(0, 1, wa(1), 1, wb(0), 0, 1, wa(0), 1, 1, S_ACT);  // 11
    add(0, 1, wa(1), 1, wb(1), 1, 0, wb(0), 1, 1, S_ACT);  // 12
    add(0, 0, 0,     1, wb(1), 0, 1, wa(1), 1, 1, S_ACT);  // 13: only req1
    add(0, 0, 0,     1, wb(2), 0, 1, wb(1), 1, 1, S_ACT);  // 14
    add(0, 0, 0,     1, wb(3), 0, 1, wb(2), 1, 1, S_ACT);  // 15
    add(0, 0, 0,     1, wb(4), 0, 1, wb(3), 1, 1, S_ACT);  // 16
    add(0, 0, 0,     1, wb(5), 0, 1, wb(4), 1, 1, S_ACT);  // 17
    add(0, 1, wa(2), 1, wb(6), 1, 0, wb(5), 1, 1, S_ACT);  // 18: req0 first
    add(0, 1, wa(3), 1, wb(6), 0, 1, wa(2), 1, 1, S_ACT);  // 19
    add(0, 1, wa(3), 0, 0,     1, 0, wb(6), 1, 1, S_ACT);  // 20
    add(0, 0, 0,     0, 0,     0, 0, wa(3), 1, 1, S_ACT);  // 21
    add(0, 0, 0,     0, 0,     0, 0, 0,     0, 1, S_ACT);  // 22
    // ---- rows 23-28: 16th ACTIVE cycle is row 24 ----
    add(0, 1, wa(4), 1, wb(8), 0, 1, 0,     0, 1, S_ACT);  // 23
    add(0, 1, wa(4), 1, wb(9), 1, 0, wb(8), 1, 1, S_ACT);  // 24
`ifdef PHY_TX_SCHED_SKP_EN
    add(1, 1, wa(5), 1, wb(9), 0, 0, wa(4), 1, 1, S_SKIP); // 25: retrain ignored
    add(0, 1, wa(5), 1, wb(9), 0, 1, SP,    1, 1, S_ACT);  // 26: ptr kept
    add(0, 1, wa(5), 0, 0,     1, 0, wb(9), 1, 1, S_ACT);  // 27
    add(0, 0, 0,     0, 0,     0, 0, wa(5), 1, 1, S_ACT);  // 28
`else
    add(0, 1, wa(5), 1, wb(9), 0, 1, wa(4), 1, 1, S_ACT);  // 25: no SKIP
    add(0, 1, wa(5), 0, 0,     1, 0, wb(9), 1, 1, S_ACT);  // 26
    add(0, 0, 0,     0, 0,     0, 0, wa(5), 1, 1, S_ACT);  // 27
    add(0, 0, 0,     0, 0,     0, 0, 0,     0, 1, S_ACT);  // 28
`endif
    // ---- rows 29-40: retrain while req0 is granted ----
    add(1, 1, wa(6), 0, 0,      1, 0, 0,     0, 1, S_ACT);   // 29
    add(0, 0, 0,     1, wb(10), 0, 0, wa(6), 1, 0, S_TRAIN); // 30
    for (int k = 31; k <= 37; k++)
      add((k == 33) ? 1'b1 : 1'b0, 0, 0, 1, wb(10), 0, 0, TP, 1, 0, S_TRAIN);
    add(0, 0, 0, 1, wb(10), 0, 1, TP,     1, 1, S_ACT);    // 38
    add(0, 0, 0, 0, 0,      0, 0, wb(10), 1, 1, S_ACT);    // 39
    add(0, 0, 0, 0, 0,      0, 0, 0,      0, 1, S_ACT);    // 40

    // ---- reset state, with both valids high ----
    rst_v = '{rt: 0, v0: 1, d0: 0, v1: 1, d1: 0, r0: 0, r1: 0,
              txd: 0, txv: 0, lu: 0, st: S_IDLE};
    @(negedge clk_f);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_outputs("in_reset", rst_v);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk_f);

    // ---- reset asserted while training word 4 is on tx_data ----
    reset = 1'b0;
    run_range(0, 4);
    #1;
    check("pre_reset tx_data", tx_data, TP);
    #1;
    reset = 1'b1;
    #1;
    check_outputs("mid_train_reset", rst_v);
    @(negedge clk_f);
    check("held_reset state", 32'(state), 32'(S_IDLE));

    // ---- full run from a clean release ----
    reset = 1'b0;
    run_range(0, tbl.size() - 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
